branch_outcome_queue: RTL

//  In-order queue of in-flight branch predictions, sitting directly downstream of the
//  2-bit saturating-counter predictor. Stores each issued prediction until the branch

---
 rtl/branch_outcome_queue_if.sv | 44 ++++
 rtl/branch_outcome_queue.sv | 118 +++++++++++
 2 files changed

// File: rtl/branch_outcome_queue_if.sv
// ----------------------------------------------------------------------------
// branch_outcome_queue_if
//   Bundles the prediction enqueue handshake, the resolution handshake, the
//   predictor update pulse and the statistics outputs of branch_outcome_queue.
//   slave  : the queue itself (accepts predictions/resolutions, drives status)
//   master : the surrounding pipeline (offers predictions/resolutions)
// Signals
//   pred_valid/pred_taken/pred_ready : prediction enqueue handshake
//   res_valid/res_taken/res_ready    : resolution (dequeue) handshake
//   result/taken                     : one-cycle predictor update pulse + outcome
//   mispredict/res_err               : one-cycle event pulses
//   count                            : current occupancy (PTR_W+1 bits)
//   branch_cnt/mispred_cnt           : saturating statistics (CNT_W bits)
// ----------------------------------------------------------------------------
interface branch_outcome_queue_if #(
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
);
  logic             pred_valid;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             res_ready;
  logic             result;
  logic             taken;
  logic             mispredict;
  logic             res_err;
  logic [PTR_W:0]   count;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport slave (
    input  pred_valid, pred_taken, res_valid, res_taken,
    output pred_ready, res_ready, result, taken, mispredict, res_err,
           count, branch_cnt, mispred_cnt
  );

  modport master (
    output pred_valid, pred_taken, res_valid, res_taken,
    input  pred_ready, res_ready, result, taken, mispredict, res_err,
           count, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_outcome_queue.sv
// ----------------------------------------------------------------------------
// branch_outcome_queue
//   In-order queue of in-flight branch predictions. Each accepted prediction
//   is held until its branch resolves; the resolution is compared against the
//   stored direction, producing a one-cycle predictor update pulse and, on a
//   mismatch, a mispredict pulse plus a flush of every younger entry.
//   Saturating counters track resolved and mispredicted branches.
// Ports
//   i_clk   : rising-edge clock
//   i_rst_n : synchronous active-low reset
//   bus     : branch_outcome_queue_if.slave (handshakes, pulses, statistics)
// ----------------------------------------------------------------------------
module branch_outcome_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  branch_outcome_queue_if.slave  bus
);

  localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             r_result;
  logic             r_taken;
  logic             r_mispredict;
  logic             r_res_err;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic             w_pred_ready;
  logic             w_res_ready;
  logic             w_push;
  logic             w_pop;
  logic             w_head;
  logic             w_miss;
  logic [PTR_W:0]   w_count_next;

  // Readiness depends on occupancy alone so neither handshake can form a
  // combinational loop through the valid inputs.
  assign w_pred_ready = (r_count != COUNT_FULL);
  assign w_res_ready  = (r_count != '0);

  assign w_push = bus.pred_valid && w_pred_ready;
  assign w_pop  = bus.res_valid  && w_res_ready;
  assign w_head = r_mem[r_rd_ptr];
  assign w_miss = w_pop && (bus.res_taken != w_head);

  // A mispredict empties the queue, including any push accepted this cycle.
  always_comb begin
    w_count_next = r_count;
    if (w_miss) begin
      w_count_next = '0;
    end else begin
      w_count_next = r_count + {{PTR_W{1'b0}}, w_push} - {{PTR_W{1'b0}}, w_pop};
    end
  end

  // Storage needs no reset; entries are only read while counted as valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.pred_taken;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_result      <= 1'b0;
      r_taken       <= 1'b0;
      r_mispredict  <= 1'b0;
      r_res_err     <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_count   <= w_count_next;
      r_result  <= w_pop;
      r_taken   <= w_pop ? bus.res_taken : 1'b0;
      r_mispredict <= w_miss;
      r_res_err <= bus.res_valid && !w_res_ready;

      // On a flush the write pointer holds (dropping a same-cycle push) and
      // the read pointer jumps to it, leaving the queue empty.
      if (w_miss) begin
        r_rd_ptr <= r_wr_ptr;
      end else begin
        if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end

      if (w_pop && (r_branch_cnt != CNT_MAX)) begin
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      end
      if (w_miss && (r_mispred_cnt != CNT_MAX)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pred_ready  = w_pred_ready;
  assign bus.res_ready   = w_res_ready;
  assign bus.result      = r_result;
  assign bus.taken       = r_taken;
  assign bus.mispredict  = r_mispredict;
  assign bus.res_err     = r_res_err;
  assign bus.count       = r_count;
  assign bus.branch_cnt  = r_branch_cnt;
  assign bus.mispred_cnt = r_mispred_cnt;

endmodule
